fde_pipe_regs: RTL

- Front-end pipeline register bank for the 5-stage RV32I core: PC register (F), IF/ID register (D) and ID/EX register (E).
- Receives the hazard control outputs (stallF, stallD, flushD, flushE) and the branch redirect (PCSrcE, PCTargetE), and applies them to the pipeline state.
- Also keeps saturating stall and flush event counters for debug.

---
 rtl/fde_pipe_regs.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fde_pipe_regs.sv
// Fetch/decode/execute pipeline register bank: PC (F), IF/ID (D) and ID/EX (E)
// registers with stall, flush and redirect handling, plus saturating debug counters.
module fde_pipe_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             flushE,
    input  logic             PCSrcE,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      RD1D,
    input  logic [31:0]      RD2D,
    input  logic [31:0]      ImmExtD,
    input  logic [10:0]      CtrlD,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      PCPlus4D,
    output logic [4:0]       Rs1D,
    output logic [4:0]       Rs2D,
    output logic [4:0]       RdD,
    output logic             ValidD,
    output logic             ValidE,
    output logic [31:0]      RD1E,
    output logic [31:0]      RD2E,
    output logic [31:0]      ImmExtE,
    output logic [31:0]      PCE,
    output logic [31:0]      PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [10:0]      CtrlE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [31:0]      PC_STEP = 32'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones so a long debug run never reads back as small.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
        logic [CNT_W-1:0] res;
        if (hit && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // F stage state
    logic [31:0]      pcf_r;
    logic [31:0]      pc_next_s;
    logic [31:0]      pc_plus4_f_s;

    // D stage state
    logic [31:0]      instr_d_r,    instr_d_next_s;
    logic [31:0]      pc_d_r,       pc_d_next_s;
    logic [31:0]      pc_plus4_d_r, pc_plus4_d_next_s;
    logic             valid_d_r,    valid_d_next_s;
    logic [4:0]       rs1_d_s, rs2_d_s, rd_d_s;

    // E stage state
    logic [31:0]      rd1_e_r,      rd1_e_next_s;
    logic [31:0]      rd2_e_r,      rd2_e_next_s;
    logic [31:0]      imm_ext_e_r,  imm_ext_e_next_s;
    logic [31:0]      pc_e_r,       pc_e_next_s;
    logic [31:0]      pc_plus4_e_r, pc_plus4_e_next_s;
    logic [4:0]       rs1_e_r,      rs1_e_next_s;
    logic [4:0]       rs2_e_r,      rs2_e_next_s;
    logic [4:0]       rd_e_r,       rd_e_next_s;
    logic [10:0]      ctrl_e_r,     ctrl_e_next_s;
    logic             valid_e_r,    valid_e_next_s;

    // Debug counters
    logic [CNT_W-1:0] stall_cnt_r, stall_cnt_next_s;
    logic [CNT_W-1:0] flush_cnt_r, flush_cnt_next_s;

    assign pc_plus4_f_s = pcf_r + PC_STEP;
    assign rs1_d_s      = instr_d_r[19:15];
    assign rs2_d_s      = instr_d_r[24:20];
    assign rd_d_s       = instr_d_r[11:7];

    // Next fetch PC: a resolved redirect beats stallF so a taken branch is never dropped.
    always_comb begin
        pc_next_s = pcf_r;
        if (PCSrcE) begin
            pc_next_s = PCTargetE;
        end else if (stallF) begin
            pc_next_s = pcf_r;
        end else begin
            pc_next_s = pc_plus4_f_s;
        end
    end

    // IF/ID next state: flush wins over stall.
    always_comb begin
        instr_d_next_s    = instr_d_r;
        pc_d_next_s       = pc_d_r;
        pc_plus4_d_next_s = pc_plus4_d_r;
        valid_d_next_s    = valid_d_r;
        if (flushD) begin
            instr_d_next_s    = NOP_INSTR;
            pc_d_next_s       = 32'h0000_0000;
            pc_plus4_d_next_s = 32'h0000_0000;
            valid_d_next_s    = 1'b0;
        end else if (stallD) begin
            instr_d_next_s    = instr_d_r;
            pc_d_next_s       = pc_d_r;
            pc_plus4_d_next_s = pc_plus4_d_r;
            valid_d_next_s    = valid_d_r;
        end else begin
            instr_d_next_s    = InstrF;
            pc_d_next_s       = pcf_r;
            pc_plus4_d_next_s = pc_plus4_f_s;
            valid_d_next_s    = 1'b1;
        end
    end

    // ID/EX next state: E never holds; a flush zeroes CtrlE so the bubble has no side effects.
    always_comb begin
        rd1_e_next_s      = RD1D;
        rd2_e_next_s      = RD2D;
        imm_ext_e_next_s  = ImmExtD;
        pc_e_next_s       = pc_d_r;
        pc_plus4_e_next_s = pc_plus4_d_r;
        rs1_e_next_s      = rs1_d_s;
        rs2_e_next_s      = rs2_d_s;
        rd_e_next_s       = rd_d_s;
        ctrl_e_next_s     = CtrlD;
        valid_e_next_s    = valid_d_r;
        if (flushE) begin
            rd1_e_next_s      = 32'h0000_0000;
            rd2_e_next_s      = 32'h0000_0000;
            imm_ext_e_next_s  = 32'h0000_0000;
            pc_e_next_s       = 32'h0000_0000;
            pc_plus4_e_next_s = 32'h0000_0000;
            rs1_e_next_s      = 5'd0;
            rs2_e_next_s      = 5'd0;
            rd_e_next_s       = 5'd0;
            ctrl_e_next_s     = 11'd0;
            valid_e_next_s    = 1'b0;
        end else begin
            valid_e_next_s    = valid_d_r;
        end
    end

    // Debug event counters.
    always_comb begin
        stall_cnt_next_s = sat_inc(stall_cnt_r, stallF);
        flush_cnt_next_s = sat_inc(flush_cnt_r, flushD | flushE);
    end

    // Pipeline state registers; reset overrides any stall in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_r        <= RESET_PC;
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
            rd1_e_r      <= 32'h0000_0000;
            rd2_e_r      <= 32'h0000_0000;
            imm_ext_e_r  <= 32'h0000_0000;
            pc_e_r       <= 32'h0000_0000;
            pc_plus4_e_r <= 32'h0000_0000;
            rs1_e_r      <= 5'd0;
            rs2_e_r      <= 5'd0;
            rd_e_r       <= 5'd0;
            ctrl_e_r     <= 11'd0;
            valid_e_r    <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            pcf_r        <= pc_next_s;
            instr_d_r    <= instr_d_next_s;
            pc_d_r       <= pc_d_next_s;
            pc_plus4_d_r <= pc_plus4_d_next_s;
            valid_d_r    <= valid_d_next_s;
            rd1_e_r      <= rd1_e_next_s;
            rd2_e_r      <= rd2_e_next_s;
            imm_ext_e_r  <= imm_ext_e_next_s;
            pc_e_r       <= pc_e_next_s;
            pc_plus4_e_r <= pc_plus4_e_next_s;
            rs1_e_r      <= rs1_e_next_s;
            rs2_e_r      <= rs2_e_next_s;
            rd_e_r       <= rd_e_next_s;
            ctrl_e_r     <= ctrl_e_next_s;
            valid_e_r    <= valid_e_next_s;
            stall_cnt_r  <= stall_cnt_next_s;
            flush_cnt_r  <= flush_cnt_next_s;
        end
    end

    assign PCF      = pcf_r;
    assign InstrD   = instr_d_r;
    assign PCD      = pc_d_r;
    assign PCPlus4D = pc_plus4_d_r;
    assign Rs1D     = rs1_d_s;
    assign Rs2D     = rs2_d_s;
    assign RdD      = rd_d_s;
    assign ValidD   = valid_d_r;
    assign ValidE   = valid_e_r;
    assign RD1E     = rd1_e_r;
    assign RD2E     = rd2_e_r;
    assign ImmExtE  = imm_ext_e_r;
    assign PCE      = pc_e_r;
    assign PCPlus4E = pc_plus4_e_r;
    assign Rs1E     = rs1_e_r;
    assign Rs2E     = rs2_e_r;
    assign RdE      = rd_e_r;
    assign CtrlE    = ctrl_e_r;
    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;

endmodule
